axil_default_slave: RTL and testbench
=====================================

Name: axil_default_slave

Overview:
- Terminating AXI-Lite slave for the decode-miss slot of the AXI-Lite priority interconnect (the extra index NUMBER_SLAVE).
- Any write or read the address decoders route to no mapped slave lands here.
- It completes the handshake with a decode-error response, so the master never hangs.
- It also keeps saturating error counters and captures the last offending address for debug/status.

Parameters:
- AXI_ADDR_WIDTH, 32, width of awaddr/araddr/last_err_addr
- AXI_DATA_WIDTH, 32, width of wdata/rdata
- RDATA_PATTERN, 32'hDEAD_BEEF (sized to AXI_DATA_WIDTH), constant driven on rdata during an error read
- RESP_CODE, 2'b11, value driven on bresp/rresp (DECERR)
- CNT_WIDTH, 16, width of the error counters

Ports:
- aclk  input  1  clock
- aresetn  input  1  synchronous active-low reset
- s_axil_awaddr  input  AXI_ADDR_WIDTH  write address
- s_axil_awvalid  input  1  write address valid
- s_axil_awready  output  1  write address ready
- s_axil_wdata  input  AXI_DATA_WIDTH  write data (discarded)
- s_axil_wstrb  input  AXI_DATA_WIDTH/8  write strobes (discarded)
- s_axil_wvalid  input  1  write data valid
- s_axil_wready  output  1  write data ready
- s_axil_bresp  output  2  write response
- s_axil_bvalid  output  1  write response valid
- s_axil_bready  input  1  write response ready
- s_axil_araddr  input  AXI_ADDR_WIDTH  read address
- s_axil_arvalid  input  1  read address valid
- s_axil_arready  output  1  read address ready
- s_axil_rdata  output  AXI_DATA_WIDTH  read data
- s_axil_rresp  output  2  read response
- s_axil_rvalid  output  1  read data valid
- s_axil_rready  input  1  read data ready
- err_wr_cnt  output  CNT_WIDTH  completed error writes, saturating
- err_rd_cnt  output  CNT_WIDTH  completed error reads, saturating
- last_err_addr  output  AXI_ADDR_WIDTH  address of most recent accepted error transaction

Behaviour:
- Single clock aclk; reset is synchronous, active-low on aresetn.
- Reset values: all ready/valid outputs 0; bresp, rresp, rdata, counters and last_err_addr all 0. State machines go to IDLE.
- All outputs are registered. Ready signals rise in the first cycle after aresetn goes high.
- Write FSM states: W_IDLE, W_RESP. Two flags, aw_done and w_done, track captured phases.
- W_IDLE, address channel: awready=1 while !aw_done. An AW handshake (awvalid&&awready) sets aw_done, captures awaddr, and drops awready next cycle.
- W_IDLE, data channel: wready=1 while !w_done. A W handshake sets w_done and drops wready next cycle. Data and strobes are ignored.
- AW and W may arrive in either order or in the same cycle.
- When both phases are complete (flag set or handshake this cycle): next cycle bvalid=1, bresp=RESP_CODE, state=W_RESP.
- Latency: AW+W handshake together in cycle n gives bvalid=1 in cycle n+1.
- W_RESP: bvalid is held with stable bresp until bready. Awready and wready stay 0.
- B handshake in cycle m: in m+1, bvalid=0, bresp=0, flags cleared, awready=wready=1, state=W_IDLE. err_wr_cnt increments in m+1.
- Minimum write period is 2 cycles.
- Read FSM states: R_IDLE, R_RESP.
- R_IDLE: arready=1. An AR handshake in cycle n gives, in n+1: arready=0, rvalid=1, rdata=RDATA_PATTERN, rresp=RESP_CODE, state=R_RESP. araddr is captured.
- R_RESP: rdata/rresp are held stable until rready.
- R handshake in cycle m: in m+1, rvalid=0, rdata=0, rresp=0, arready=1, err_rd_cnt increments.
- Read and write FSMs are fully independent and may be busy concurrently.
- Counters saturate at all-ones and never wrap.
- last_err_addr is updated on the AW or AR handshake cycle (visible next cycle). If AW and AR handshake in the same cycle, awaddr wins.
- Valid and data held across stalls (bready/rready low for any number of cycles) must not change.
- Reset mid-transaction: any pending response is dropped. Outputs return to reset values next edge; counters and last_err_addr are cleared.

Test Plan:
- Reset then idle: aresetn low 3 cycles -> all outputs 0. First cycle after release: awready=wready=arready=1.
- Write, aligned: awaddr=32'h9000_0000, awvalid=wvalid=1 in cycle n, bready=1 -> bvalid=1, bresp=2'b11 in n+1; bvalid=0 in n+2; err_wr_cnt=1; last_err_addr=32'h9000_0000.
- Write, W before AW by 3 cycles, bready held low 5 cycles -> wready drops after W; bvalid rises the cycle after AW; bvalid/bresp stable through the stall; single count increment.
- Read: araddr=32'hF000_0010, rready low 2 cycles -> rvalid=1, rdata=32'hDEAD_BEEF, rresp=2'b11 held 3 cycles; err_rd_cnt=1.
- Concurrent: AW+W and AR handshake in the same cycle with awaddr=32'h1, araddr=32'h2 -> bvalid and rvalid both rise next cycle; last_err_addr=32'h1; both counters=1.
- Saturation and reset: CNT_WIDTH=2, 5 writes -> err_wr_cnt stays 2'b11. Assert reset while bvalid=1 -> bvalid=0 and counter=0 next cycle; no stray B after release.

Source files
------------

// File: rtl/axil_default_slave.sv
// Decode-miss AXI-Lite slave: completes every write/read with a DECERR response,
// keeps saturating error counters and records the last offending address.
module axil_default_slave #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter logic [AXI_DATA_WIDTH-1:0] RDATA_PATTERN  = 32'hDEAD_BEEF,
  parameter logic [1:0]                RESP_CODE      = 2'b11,
  parameter int                        CNT_WIDTH      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [CNT_WIDTH-1:0]          err_wr_cnt,
  output logic [CNT_WIDTH-1:0]          err_rd_cnt,
  output logic [AXI_ADDR_WIDTH-1:0]     last_err_addr
);

  // state    | meaning
  // W_IDLE   | collecting AW and W phases, either order
  // W_RESP   | DECERR on B, waiting for bready
  // R_IDLE   | arready high, waiting for AR
  // R_RESP   | DECERR + pattern on R, waiting for rready
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                      awready_q, awready_d, wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [CNT_WIDTH-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  logic aw_hs, w_hs, ar_hs, aw_seen, w_seen;
  logic unused_wdata;

  // Write payload is intentionally discarded.
  assign unused_wdata = ^{s_axil_wdata, s_axil_wstrb};

  assign aw_hs   = s_axil_awvalid & awready_q;
  assign w_hs    = s_axil_wvalid  & wready_q;
  assign ar_hs   = s_axil_arvalid & arready_q;
  assign aw_seen = aw_done_q | aw_hs;
  assign w_seen  = w_done_q  | w_hs;

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_cnt_d  = wr_cnt_q;
    case (w_state_q)
      W_IDLE: begin
        aw_done_d = aw_seen;
        w_done_d  = w_seen;
        if (aw_seen && w_seen) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_CODE;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else begin
          awready_d = !aw_seen;
          wready_d  = !w_seen;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          if (wr_cnt_q != {CNT_WIDTH{1'b1}}) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_cnt_d  = rd_cnt_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = RDATA_PATTERN;
          rresp_d   = RESP_CODE;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rdata_d   = '0;
          rresp_d   = 2'b00;
          if (rd_cnt_q != {CNT_WIDTH{1'b1}}) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write address takes priority when both channels handshake together.
  always_comb begin
    last_addr_d = last_addr_q;
    if (aw_hs)      last_addr_d = s_axil_awaddr;
    else if (ar_hs) last_addr_d = s_axil_araddr;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      last_addr_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign err_wr_cnt     = wr_cnt_q;
  assign err_rd_cnt     = rd_cnt_q;
  assign last_err_addr  = last_addr_q;

endmodule

// File: tb/tb_axil_default_slave.sv
// Bench for axil_default_slave: directed scenarios plus random traffic, all checked
// against a transaction-level model; a second instance uses 2-bit counters.
module tb_axil_default_slave;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, last_addr;
  logic [15:0] wr_cnt, rd_cnt;

  logic        awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
  logic [1:0]  bresp_s, rresp_s;
  logic [31:0] rdata_s, last_addr_s;
  logic [1:0]  wr_cnt_s, rd_cnt_s;

  axil_default_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .err_wr_cnt(wr_cnt), .err_rd_cnt(rd_cnt), .last_err_addr(last_addr)
  );

  axil_default_slave #(.CNT_WIDTH(2)) dut_sat (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready_s),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready_s),
    .s_axil_bresp(bresp_s), .s_axil_bvalid(bvalid_s), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready_s),
    .s_axil_rdata(rdata_s), .s_axil_rresp(rresp_s), .s_axil_rvalid(rvalid_s), .s_axil_rready(rready),
    .err_wr_cnt(wr_cnt_s), .err_rd_cnt(rd_cnt_s), .last_err_addr(last_addr_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: a write owes a DECERR once both its address and data
  // have been taken; a read owes one once its address has been taken.
  logic        e_awready, e_wready, e_bvalid, e_arready, e_rvalid;
  logic [1:0]  e_bresp, e_rresp;
  logic [31:0] e_rdata, e_last;
  logic        got_aw, got_w;
  int          e_wcnt, e_rcnt;
  logic        m_awhs, m_whs, m_arhs;

  always @(posedge aclk) begin : model
    m_awhs = awvalid && e_awready;
    m_whs  = wvalid  && e_wready;
    m_arhs = arvalid && e_arready;
    if (!aresetn) begin
      {e_awready, e_wready, e_bvalid, e_arready, e_rvalid} = '0;
      e_bresp = 0; e_rresp = 0; e_rdata = 0; e_last = 0;
      got_aw = 0; got_w = 0; e_wcnt = 0; e_rcnt = 0;
      m_awhs = 0; m_whs = 0; m_arhs = 0;
    end else begin
      if (m_awhs)      e_last = awaddr;
      else if (m_arhs) e_last = araddr;
      if (e_bvalid) begin
        if (bready) begin
          e_bvalid = 0; e_bresp = 0; got_aw = 0; got_w = 0; e_wcnt++;
        end
      end else begin
        got_aw = got_aw | m_awhs;
        got_w  = got_w  | m_whs;
        if (got_aw && got_w) begin e_bvalid = 1; e_bresp = 2'b11; end
      end
      e_awready = !e_bvalid && !got_aw;
      e_wready  = !e_bvalid && !got_w;
      if (e_rvalid) begin
        if (rready) begin e_rvalid = 0; e_rdata = 0; e_rresp = 0; e_rcnt++; end
      end else if (m_arhs) begin
        e_rvalid = 1; e_rdata = 32'hDEAD_BEEF; e_rresp = 2'b11;
      end
      e_arready = !e_rvalid;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  logic chk_en = 1'b0;
  always @(negedge aclk) begin
    if (chk_en) begin
      chk("awready", awready, e_awready);
      chk("wready",  wready,  e_wready);
      chk("bvalid",  bvalid,  e_bvalid);
      chk("bresp",   bresp,   e_bresp);
      chk("arready", arready, e_arready);
      chk("rvalid",  rvalid,  e_rvalid);
      chk("rdata",   rdata,   e_rdata);
      chk("rresp",   rresp,   e_rresp);
      chk("wr_cnt",  wr_cnt,  sat(e_wcnt, 65535));
      chk("rd_cnt",  rd_cnt,  sat(e_rcnt, 65535));
      chk("last",    last_addr, e_last);
      chk("s_bvalid", bvalid_s, e_bvalid);
      chk("s_rvalid", rvalid_s, e_rvalid);
      chk("s_wr_cnt", wr_cnt_s, sat(e_wcnt, 3));
      chk("s_rd_cnt", rd_cnt_s, sat(e_rcnt, 3));
    end
  end

  task automatic clear_valids();
    awvalid = 0; wvalid = 0; arvalid = 0;
  endtask

  task automatic reset_dut(input int n);
    aresetn = 0; clear_valids();
    repeat (n) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
  endtask

  task automatic do_write(input logic [31:0] a);
    awaddr = a; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge aclk);
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 0; awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;

    // reset then idle
    @(negedge aclk);
    chk_en = 1;
    repeat (2) @(negedge aclk);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_arready", arready, 1'b0);
    aresetn = 1;
    @(negedge aclk);
    chk("rel_awready", awready, 1'b1);
    chk("rel_wready",  wready,  1'b1);
    chk("rel_arready", arready, 1'b1);

    // aligned write
    awaddr = 32'h9000_0000; wdata = 32'h1234; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    @(negedge aclk);
    chk("aln_bvalid", bvalid, 1'b1);
    chk("aln_bresp",  bresp,  2'b11);
    awvalid = 0; wvalid = 0;
    @(negedge aclk);
    chk("aln_bvalid_low", bvalid, 1'b0);
    chk("aln_cnt", wr_cnt, 16'd1);
    chk("aln_last", last_addr, 32'h9000_0000);

    // W three cycles ahead of AW, B stalled five cycles
    wvalid = 1; bready = 0;
    @(negedge aclk);
    chk("wfirst_wready", wready, 1'b0);
    wvalid = 0;
    repeat (2) @(negedge aclk);
    chk("wfirst_no_b", bvalid, 1'b0);
    awaddr = 32'hA000_0004; awvalid = 1;
    @(negedge aclk);
    chk("wfirst_bvalid", bvalid, 1'b1);
    awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("stall_bvalid", bvalid, 1'b1);
      chk("stall_bresp",  bresp,  2'b11);
    end
    bready = 1;
    @(negedge aclk);
    chk("wfirst_done", bvalid, 1'b0);
    chk("wfirst_cnt", wr_cnt, 16'd2);

    // read with two-cycle R stall
    araddr = 32'hF000_0010; arvalid = 1; rready = 0;
    @(negedge aclk);
    arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_rvalid", rvalid, 1'b1);
      chk("rd_rdata",  rdata,  32'hDEAD_BEEF);
      chk("rd_rresp",  rresp,  2'b11);
      if (i == 2) rready = 1;
      @(negedge aclk);
    end
    chk("rd_done", rvalid, 1'b0);
    chk("rd_cnt1", rd_cnt, 16'd1);
    chk("rd_last", last_addr, 32'hF000_0010);

    // concurrent write and read
    reset_dut(2);
    awaddr = 32'h1; araddr = 32'h2;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    @(negedge aclk);
    chk("cc_bvalid", bvalid, 1'b1);
    chk("cc_rvalid", rvalid, 1'b1);
    chk("cc_last", last_addr, 32'h1);
    clear_valids();
    @(negedge aclk);
    chk("cc_wcnt", wr_cnt, 16'd1);
    chk("cc_rcnt", rd_cnt, 16'd1);

    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge aclk);
      if (!(awvalid && !m_awhs)) begin awvalid = ($urandom_range(0, 2) == 0); awaddr = $urandom; end
      if (!(wvalid && !m_whs))   begin wvalid = ($urandom_range(0, 2) == 0); wdata = $urandom; wstrb = 4'($urandom); end
      if (!(arvalid && !m_arhs)) begin arvalid = ($urandom_range(0, 2) == 0); araddr = $urandom; end
      bready  = ($urandom_range(0, 3) != 0);
      rready  = ($urandom_range(0, 3) != 0);
      aresetn = ($urandom_range(0, 399) != 0);
    end

    // saturation, then reset with a B pending
    @(negedge aclk);
    reset_dut(2);
    for (int i = 0; i < 5; i++) do_write(32'h100 + i);
    chk("sat_cnt2", wr_cnt_s, 2'b11);
    chk("sat_cnt16", wr_cnt, 16'd5);
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge aclk);
    chk("pend_bvalid", bvalid_s, 1'b1);
    clear_valids();
    aresetn = 0;
    @(negedge aclk);
    chk("rstmid_bvalid", bvalid_s, 1'b0);
    chk("rstmid_cnt", wr_cnt_s, 2'b00);
    chk("rstmid_last", last_addr_s, 32'h0);
    aresetn = 1; bready = 1;
    repeat (5) begin
      @(negedge aclk);
      chk("no_stray_b", bvalid_s, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
